// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: block load/store multiple beat sequencer with optional base writeback.
// Define LDM_STM_BASE_WRITEBACK_EN to enable the WBASE base-register writeback state.
module ldm_stm_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic [15:0] reg_list,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_addr,
  input  logic        up,
  input  logic        pre,
  input  logic        wb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] reg_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [4:0]  rd_reg_num,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        regwrite,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DONE  = 2'd2
`ifdef LDM_STM_BASE_WRITEBACK_EN
    , WBASE = 2'd3
`endif
  } state_t;
  state_t      state;
  logic [31:0] addr_q;
  logic [15:0] list_q;
  logic        load_q;
  logic [4:0]  n;
  logic [3:0]  cur;
  logic [31:0] span, first_addr;
  logic        last, xfer, store, ld_beat;
  always_comb begin
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(reg_list[i]);
    cur = '0;
    for (int i = 15; i >= 0; i--) if (list_q[i]) cur = 4'(i);
  end
  assign span       = {25'b0, n, 2'b0};
  assign first_addr = up ? (pre ? base_addr + 32'd4 : base_addr)
                         : (pre ? base_addr - span : base_addr - span + 32'd4);
  // list_q holds the registers still to transfer; one set bit left means last beat
  assign last    = (list_q & (list_q - 16'd1)) == 16'd0;
  assign xfer    = state == XFER;
  assign store   = xfer && !load_q;
  assign ld_beat = xfer && load_q && mem_ready;
  assign mem_req    = xfer;
  assign mem_we     = store;
  assign mem_addr   = xfer ? addr_q : '0;
  assign rd_reg_num = store ? {1'b0, cur} : '0;
  assign mem_wdata  = store ? reg_rdata : '0;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
`ifdef LDM_STM_BASE_WRITEBACK_EN
  logic [31:0] final_q;
  logic [3:0]  base_reg_q;
  logic        wb_ok_q;
  logic        wbase;
  assign wbase      = state == WBASE;
  assign regwrite   = ld_beat || wbase;
  assign write_reg  = ld_beat ? {1'b0, cur} : wbase ? {1'b0, base_reg_q} : '0;
  assign write_data = ld_beat ? mem_rdata : wbase ? final_q : '0;
`else
  logic unused_cfg;
  assign unused_cfg = ^{wb, base_reg};
  assign regwrite   = ld_beat;
  assign write_reg  = ld_beat ? {1'b0, cur} : '0;
  assign write_data = ld_beat ? mem_rdata : '0;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      list_q <= '0;
      load_q <= 1'b0;
`ifdef LDM_STM_BASE_WRITEBACK_EN
      final_q    <= '0;
      base_reg_q <= '0;
      wb_ok_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          addr_q <= first_addr;
          list_q <= reg_list;
          load_q <= is_load;
`ifdef LDM_STM_BASE_WRITEBACK_EN
          final_q    <= up ? base_addr + span : base_addr - span;
          base_reg_q <= base_reg;
          wb_ok_q    <= wb && !(is_load && reg_list[base_reg]);
`endif
          state <= (n == 5'd0) ? DONE : XFER;
        end
        XFER: if (mem_ready) begin
          addr_q <= addr_q + 32'd4;
          list_q <= list_q & (list_q - 16'd1);
`ifdef LDM_STM_BASE_WRITEBACK_EN
          if (last) state <= wb_ok_q ? WBASE : DONE;
`else
          if (last) state <= DONE;
`endif
        end
`ifdef LDM_STM_BASE_WRITEBACK_EN
        WBASE: state <= DONE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: directed scoreboard bench for ldm_stm_sequencer.
module tb_ldm_stm_sequencer;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, is_load = 1'b0;
  logic        up = 1'b0, pre = 1'b0, wb = 1'b0, mem_ready = 1'b1;
  logic [15:0] reg_list = '0;
  logic [3:0]  base_reg = '0;
  logic [31:0] base_addr = '0;
  logic [31:0] mem_rdata, reg_rdata;
  logic        mem_req, mem_we, regwrite, busy, done;
  logic [31:0] mem_addr, mem_wdata, write_data;
  logic [4:0]  rd_reg_num, write_reg;
  int n_chk = 0, n_fail = 0;
  localparam int BEAT = 0, WR = 1, DN = 2;
`ifdef LDM_STM_BASE_WRITEBACK_EN
  localparam int WBK = 1;
`else
  localparam int WBK = 0;
`endif
  typedef struct {int kind; logic we; logic [31:0] a; logic [31:0] d;} ev_t;
  ev_t exp_q[$];
  ev_t me;
  bit  mok;
  ldm_stm_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .is_load(is_load), .reg_list(reg_list),
    .base_reg(base_reg), .base_addr(base_addr), .up(up), .pre(pre), .wb(wb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .reg_rdata(reg_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rd_reg_num(rd_reg_num), .write_reg(write_reg), .write_data(write_data),
    .regwrite(regwrite), .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  assign mem_rdata = mem_addr ^ 32'h5A5A_0000;
  assign reg_rdata = 32'hC0DE_0000 | {27'b0, rd_reg_num};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask
  task automatic push(input int kind, input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{kind, we, a, d});
  endtask
  task automatic pop(input int kind, output ev_t e, output bit ok);
    ok = exp_q.size() > 0;
    e  = '{0, 1'b0, 32'h0, 32'h0};
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected event: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("event kind", kind, e.kind);
    end
  endtask
  always @(negedge clock) if (!reset) begin
    if (mem_req && mem_ready) begin
      pop(BEAT, me, mok);
      if (mok) begin
        chk("beat we", 32'(mem_we), 32'(me.we));
        chk("beat addr", mem_addr, me.a);
        if (me.we) chk("beat wdata", mem_wdata, me.d);
      end
    end
    if (regwrite) begin
      pop(WR, me, mok);
      if (mok) begin
        chk("write_reg", 32'(write_reg), me.a);
        chk("write_data", write_data, me.d);
      end
    end
    if (done) pop(DN, me, mok);
  end
  task automatic xfer(input logic ld, input logic u, input logic p, input logic w,
                      input logic [3:0] br, input logic [15:0] rl, input logic [31:0] ba,
                      input int exp_k, input int stall, input logic hold,
                      input logic [31:0] sa, input logic [4:0] sr);
    int k;
    bit seen;
    @(posedge clock); #1;
    is_load = ld; up = u; pre = p; wb = w; base_reg = br; reg_list = rl; base_addr = ba;
    mem_ready = (stall == 0); start = 1'b1;
    @(posedge clock); #1;
    start = hold; reg_list = 16'hFFFF; base_addr = 32'hDEAD_0000;
    is_load = ~ld; up = ~u; pre = ~p; wb = ~w; base_reg = ~br;
    k = 0;
    seen = 0;
    while (!seen && k < 40) begin
      @(negedge clock);
      k++;
      if (k <= stall) begin
        chk("stall mem_req", 32'(mem_req), 32'd1);
        chk("stall mem_addr", mem_addr, sa);
        chk("stall regwrite", 32'(regwrite), 32'd0);
        if (!ld) chk("stall rd_reg_num", 32'(rd_reg_num), 32'(sr));
      end
      if (done) begin
        seen = 1;
        start = 1'b0;
        chk("done cycle", k, exp_k);
      end
      if (k == stall) begin
        @(posedge clock); #1 mem_ready = 1'b1;
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      start = 1'b0;
      $display("FAIL done timeout: got none in %0d cycles expected at %0d", k, exp_k);
    end
  endtask
  initial begin
    #1;
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset regwrite", 32'(regwrite), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset write_data", write_data, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("release mem_req", 32'(mem_req), 0);
    chk("release regwrite", 32'(regwrite), 0);
    // STM IA r1,r2
    push(BEAT, 1, 32'h100, 32'hC0DE_0001);
    push(BEAT, 1, 32'h104, 32'hC0DE_0002);
    push(DN, 0, 0, 0);
    xfer(0, 1, 0, 0, 4'd0, 16'h0006, 32'h100, 3, 0, 0, 0, 0);
    // LDM DB r0,r15 with base writeback to r13
    push(BEAT, 0, 32'h1F8, 0);
    push(WR, 0, 32'd0, 32'h5A5A_01F8);
    push(BEAT, 0, 32'h1FC, 0);
    push(WR, 0, 32'd15, 32'h5A5A_01FC);
    if (WBK == 1) push(WR, 0, 32'd13, 32'h1F8);
    push(DN, 0, 0, 0);
    xfer(1, 0, 1, 1, 4'd13, 16'h8001, 32'h200, 3 + WBK, 0, 0, 0, 0);
    // LDM IA with base in list: loaded value wins
    push(BEAT, 0, 32'h80, 0);
    push(WR, 0, 32'd2, 32'h5A5A_0080);
    push(DN, 0, 0, 0);
    xfer(1, 1, 0, 1, 4'd2, 16'h0004, 32'h80, 2, 0, 0, 0, 0);
    // STM IB r4,r5 with 3-cycle stall and start held high
    push(BEAT, 1, 32'h404, 32'hC0DE_0004);
    push(BEAT, 1, 32'h408, 32'hC0DE_0005);
    push(DN, 0, 0, 0);
    xfer(0, 1, 1, 0, 4'd0, 16'h0030, 32'h400, 6, 3, 1, 32'h404, 5'd4);
    // empty list
    push(DN, 0, 0, 0);
    xfer(1, 1, 0, 1, 4'd3, 16'h0000, 32'h500, 1, 0, 0, 0, 0);
    // LDM DA r0,r3 with base r0 in list
    push(BEAT, 0, 32'hFFC, 0);
    push(WR, 0, 32'd0, 32'h5A5A_0FFC);
    push(BEAT, 0, 32'h1000, 0);
    push(WR, 0, 32'd3, 32'h5A5A_1000);
    push(DN, 0, 0, 0);
    xfer(1, 0, 0, 1, 4'd0, 16'h0009, 32'h1000, 3, 0, 0, 0, 0);
    // STM DB wrapping below zero, writeback r5
    push(BEAT, 1, 32'hFFFF_FFFC, 32'hC0DE_0000);
    push(BEAT, 1, 32'h0, 32'hC0DE_0001);
    if (WBK == 1) push(WR, 0, 32'd5, 32'hFFFF_FFFC);
    push(DN, 0, 0, 0);
    xfer(0, 0, 1, 1, 4'd5, 16'h0003, 32'h4, 3 + WBK, 0, 0, 0, 0);
    // reset mid-transfer
    @(posedge clock); #1;
    is_load = 0; up = 1; pre = 0; wb = 0; reg_list = 16'h000F; base_addr = 32'h300;
    mem_ready = 0; start = 1;
    @(posedge clock); #1 start = 0;
    @(negedge clock);
    chk("mid mem_req", 32'(mem_req), 1);
    chk("mid mem_addr", mem_addr, 32'h300);
    #2 reset = 1'b1;
    #1;
    chk("async mem_req", 32'(mem_req), 0);
    chk("async busy", 32'(busy), 0);
    chk("async mem_addr", mem_addr, 0);
    chk("async mem_wdata", mem_wdata, 0);
    chk("async rd_reg_num", 32'(rd_reg_num), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clock);
    chk("post mem_req", 32'(mem_req), 0);
    chk("post regwrite", 32'(regwrite), 0);
    chk("post busy", 32'(busy), 0);
    // fresh transfer after reset
    push(BEAT, 1, 32'h20, 32'hC0DE_0000);
    push(BEAT, 1, 32'h24, 32'hC0DE_0007);
    push(DN, 0, 0, 0);
    xfer(0, 1, 0, 0, 4'd0, 16'h0081, 32'h20, 3, 0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    chk("queue drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
